// File: rtl/seq_alu_pkg.sv
// Shared ALU definitions: opcode encodings and sequencer state type.
// Used by seq_alu and by the control unit's decoder.
// No logic, no latency, no flow control.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_NOT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_MUL  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the control unit (master) and seq_alu (slave).
// Ports: in_valid/in_ready/a/b/op request side; out_valid/out_ready/result/zero/overflow response side.
// Pure wiring; flow control is valid/ready on each side.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );
endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier core, low WIDTH bits of a*b.
// Latency: start pulse, then WIDTH cycles; done is high during the last iteration with prod valid.
// No backpressure: the parent samples prod in the done cycle.
// Ports: clk, rst, start, a, b in; done, prod out.
module seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] acc_d;

    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    // The final partial product is folded in combinationally so the parent
    // can register the complete product on the last iteration edge.
    assign prod  = acc_d;
    assign done  = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: 13 ops plus reserved, registered result with zero/overflow flags.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL after accept.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, in_valid ignored otherwise.
// Ports: clk, rst (async active-high), bus (seq_alu_if slave).
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic        clk,
    input logic        rst,
    seq_alu_if.slave   bus
);
    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign sum   = bus.a + bus.b;
    assign diff  = bus.a - bus.b;
    // Only the low SHW bits of B select the shift distance.
    assign shamt = bus.b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_AND:  alu_res = bus.a & bus.b;
            ALU_OR:   alu_res = bus.a | bus.b;
            ALU_NOT:  alu_res = ~bus.a;
            ALU_SLTU: alu_res = WIDTH'(bus.a < bus.b);
            ALU_SLT:  alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            ALU_XOR:  alu_res = bus.a ^ bus.b;
            ALU_NOR:  alu_res = ~(bus.a | bus.b);
            ALU_SLL:  alu_res = bus.a << shamt;
            ALU_SRL:  alu_res = bus.a >> shamt;
            ALU_SRA:  alu_res = $signed(bus.a) >>> shamt;
            // MUL is produced by seq_mul; reserved codes yield zero.
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    assign mul_start = (state_q == ST_IDLE) && bus.in_valid && (bus.op == ALU_MUL);

    seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (bus.a),
        .b     (bus.b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.op == ALU_MUL) begin
                            state_q <= ST_MUL;
                        end else begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            ovf_q    <= alu_ovf;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result_q <= mul_prod;
                        zero_q   <= (mul_prod == '0);
                        ovf_q    <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register only.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=32 (directed) and WIDTH=8 (randomised).
// Expected values come from an arithmetic reference model inside the bench.
// Latency is counted as clock edges between the accept edge and out_valid.
module tb_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus32();
    seq_alu_if #(.WIDTH(8))  bus8();

    seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain integer arithmetic on zero-extended operands of width w.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] op, output logic [63:0] res,
                                  output logic ov, output int lat);
        logic [63:0] mask;
        longint      sa, sb, full, smax, smin;
        int          sh;
        mask = (64'd1 << w) - 64'd1;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        sh   = int'(b[5:0]) % w;
        res  = 64'd0;
        ov   = 1'b0;
        lat  = 0;
        full = 0;
        case (op)
            4'd0:  begin full = sa + sb; res = 64'(full) & mask; ov = (full > smax) || (full < smin); end
            4'd1:  begin full = sa - sb; res = 64'(full) & mask; ov = (full > smax) || (full < smin); end
            4'd2:  res = a & b;
            4'd3:  res = a | b;
            4'd4:  res = ~a & mask;
            4'd5:  res = (a < b) ? 64'd1 : 64'd0;
            4'd6:  res = (sa < sb) ? 64'd1 : 64'd0;
            4'd7:  res = a ^ b;
            4'd8:  res = ~(a | b) & mask;
            4'd9:  res = (a << sh) & mask;
            4'd10: res = a >> sh;
            4'd11: res = 64'(sa >>> sh) & mask;
            4'd12: begin res = (a * b) & mask; lat = w; end
            default: res = 64'd0;
        endcase
    endfunction

    // ---------------- WIDTH=32 drivers ----------------
    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus32.a        = a;
        bus32.b        = b;
        bus32.op       = op;
        bus32.in_valid = 1'b1;
        @(posedge clk);
        #1 bus32.in_valid = 1'b0;
    endtask

    task automatic wait32(output int edges);
        edges = 0;
        while (bus32.out_valid !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1 edges++;
        end
        if (bus32.out_valid !== 1'b1) begin
            n_total++;
            $display("FAIL wait32_timeout out_valid=%b required=1", bus32.out_valid);
        end
    endtask

    task automatic take32();
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1 bus32.out_ready = 1'b0;
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output logic [31:0] res, output logic z, output logic ov, output int lat);
        start32(a, b, op);
        wait32(lat);
        res = bus32.result;
        z   = bus32.zero;
        ov  = bus32.overflow;
        take32();
    endtask

    // ---------------- WIDTH=8 drivers ----------------
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        output logic [7:0] res, output logic z, output logic ov, output int lat);
        bus8.a        = a;
        bus8.b        = b;
        bus8.op       = op;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        res = bus8.result;
        z   = bus8.zero;
        ov  = bus8.overflow;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1 bus8.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_total++; if (bus32.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus32.in_ready); else n_pass++;
        n_total++; if (bus32.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus32.out_valid); else n_pass++;
        n_total++; if (bus32.result !== 32'h0) $display("FAIL reset_result got=%h exp=0", bus32.result); else n_pass++;
        n_total++; if (bus32.zero !== 1'b0) $display("FAIL reset_zero got=%b exp=0", bus32.zero); else n_pass++;
        n_total++; if (bus32.overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", bus32.overflow); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_sub();
        logic [31:0] r; logic z, ov; int lat;
        run32(32'd5, 32'd5, ALU_SUB, r, z, ov, lat);
        n_total++; if (r !== 32'h0 || z !== 1'b1 || ov !== 1'b0)
            $display("FAIL sub_5_5 got=%h z=%b ov=%b exp=0 z=1 ov=0", r, z, ov); else n_pass++;
        run32(32'h7FFF_FFFF, 32'd1, ALU_ADD, r, z, ov, lat);
        n_total++; if (r !== 32'h8000_0000) $display("FAIL add_ovf_result got=%h exp=80000000", r); else n_pass++;
        n_total++; if (ov !== 1'b1) $display("FAIL add_ovf_flag got=%b exp=1", ov); else n_pass++;
        n_total++; if (z !== 1'b0) $display("FAIL add_ovf_zero got=%b exp=0", z); else n_pass++;
        n_total++; if (lat !== 0) $display("FAIL add_latency got=%0d exp=0 extra edges", lat); else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] r; logic z, ov; int lat;
        start32(32'd7, 32'd9, ALU_MUL);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_total++; if (bus32.out_valid !== 1'b0) $display("FAIL rstmul_out_valid got=%b exp=0", bus32.out_valid); else n_pass++;
        n_total++; if (bus32.in_ready !== 1'b1) $display("FAIL rstmul_in_ready got=%b exp=1", bus32.in_ready); else n_pass++;
        n_total++; if (bus32.result !== 32'h0 || bus32.overflow !== 1'b0)
            $display("FAIL rstmul_result got=%h ov=%b exp=0 ov=0", bus32.result, bus32.overflow); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_total++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1)
            $display("FAIL rstmul_discarded out_valid=%b in_ready=%b exp=0,1", bus32.out_valid, bus32.in_ready); else n_pass++;
        run32(32'd1, 32'd1, ALU_ADD, r, z, ov, lat);
        n_total++; if (r !== 32'd2 || lat !== 0) $display("FAIL rstmul_next_add got=%h lat=%0d exp=2 lat=0", r, lat); else n_pass++;
    endtask

    task automatic test_cmp_shift();
        logic [31:0] r; logic z, ov; int lat;
        run32(32'hFFFF_FFFF, 32'd1, ALU_SLTU, r, z, ov, lat);
        n_total++; if (r !== 32'd0 || z !== 1'b1) $display("FAIL sltu got=%h z=%b exp=0 z=1", r, z); else n_pass++;
        run32(32'hFFFF_FFFF, 32'd1, ALU_SLT, r, z, ov, lat);
        n_total++; if (r !== 32'd1 || z !== 1'b0) $display("FAIL slt got=%h z=%b exp=1 z=0", r, z); else n_pass++;
        run32(32'h8000_0000, 32'h24, ALU_SRA, r, z, ov, lat);
        n_total++; if (r !== 32'hF800_0000) $display("FAIL sra got=%h exp=f8000000", r); else n_pass++;
        run32(32'h8000_0000, 32'h24, ALU_SRL, r, z, ov, lat);
        n_total++; if (r !== 32'h0800_0000) $display("FAIL srl got=%h exp=08000000", r); else n_pass++;
        run32(32'h0000_0003, 32'hFFFF_FF21, ALU_SLL, r, z, ov, lat);
        n_total++; if (r !== 32'h0000_0006 || ov !== 1'b0) $display("FAIL sll got=%h ov=%b exp=6 ov=0", r, ov); else n_pass++;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic z, ov; int lat;
        run32(32'h0001_0003, 32'h0000_0005, ALU_MUL, r, z, ov, lat);
        n_total++; if (r !== 32'h0005_000F) $display("FAIL mul_small got=%h exp=0005000f", r); else n_pass++;
        n_total++; if (lat !== 32) $display("FAIL mul_latency got=%0d exp=32 extra edges", lat); else n_pass++;
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MUL, r, z, ov, lat);
        n_total++; if (r !== 32'h0000_0001 || ov !== 1'b0 || z !== 1'b0)
            $display("FAIL mul_ones got=%h z=%b ov=%b exp=1 z=0 ov=0", r, z, ov); else n_pass++;
        run32(32'h0001_0000, 32'h0001_0000, ALU_MUL, r, z, ov, lat);
        n_total++; if (r !== 32'h0 || z !== 1'b1) $display("FAIL mul_wrap_zero got=%h z=%b exp=0 z=1", r, z); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic z, ov; int lat;
        start32(32'h1234, 32'h4321, ALU_ADD);
        wait32(lat);
        for (int i = 0; i < 10; i++) begin
            bus32.a        = $urandom;
            bus32.b        = $urandom;
            bus32.op       = 4'($urandom_range(0, 15));
            bus32.in_valid = 1'b1;
            @(posedge clk);
            #1;
            n_total++;
            if (bus32.result !== 32'h5555 || bus32.zero !== 1'b0 || bus32.overflow !== 1'b0 ||
                bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1)
                $display("FAIL hold_cycle%0d result=%h z=%b ov=%b in_ready=%b out_valid=%b exp=5555,0,0,0,1",
                         i, bus32.result, bus32.zero, bus32.overflow, bus32.in_ready, bus32.out_valid);
            else n_pass++;
        end
        bus32.in_valid = 1'b0;
        take32();
        n_total++; if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0)
            $display("FAIL release_state in_ready=%b out_valid=%b exp=1,0", bus32.in_ready, bus32.out_valid); else n_pass++;
        run32(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_XOR, r, z, ov, lat);
        n_total++; if (r !== 32'h0FF0_0FF0 || lat !== 0)
            $display("FAIL release_next_op got=%h lat=%0d exp=0ff00ff0 lat=0", r, lat); else n_pass++;
    endtask

    task automatic test_reserved();
        logic [31:0] r; logic z, ov; int lat;
        run32(32'hDEAD_BEEF, 32'h1234_5678, 4'd14, r, z, ov, lat);
        n_total++; if (r !== 32'h0 || z !== 1'b1 || ov !== 1'b0 || lat !== 0)
            $display("FAIL reserved14 got=%h z=%b ov=%b lat=%0d exp=0,1,0,0", r, z, ov, lat); else n_pass++;
    endtask

    task automatic test_random32(input int n);
        logic [31:0] a, b, r; logic [3:0] op; logic z, ov, eov; logic [63:0] er; int lat, elat;
        for (int i = 0; i < n; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom_range(0, 15));
            model(32, {32'd0, a}, {32'd0, b}, op, er, eov, elat);
            run32(a, b, op, r, z, ov, lat);
            n_total++;
            if (r !== er[31:0] || z !== (er == 64'd0) || ov !== eov || lat !== elat)
                $display("FAIL rand32 op=%0d a=%h b=%h got=%h z=%b ov=%b lat=%0d exp=%h z=%b ov=%b lat=%0d",
                         op, a, b, r, z, ov, lat, er[31:0], (er == 64'd0), eov, elat);
            else n_pass++;
        end
    endtask

    task automatic test_random8(input int n);
        logic [7:0] corner [4];
        logic [7:0] a, b, r; logic [3:0] op; logic z, ov, eov; logic [63:0] er; int lat, elat;
        corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;
        for (int i = 0; i < n; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 3)];
            op = 4'($urandom_range(0, 15));
            model(8, {56'd0, a}, {56'd0, b}, op, er, eov, elat);
            run8(a, b, op, r, z, ov, lat);
            n_total++;
            if (r !== er[7:0] || z !== (er == 64'd0) || ov !== eov || lat !== elat)
                $display("FAIL rand8 op=%0d a=%h b=%h got=%h z=%b ov=%b lat=%0d exp=%h z=%b ov=%b lat=%0d",
                         op, a, b, r, z, ov, lat, er[7:0], (er == 64'd0), eov, elat);
            else n_pass++;
        end
    endtask

    initial begin
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
        bus32.a = '0; bus32.b = '0; bus32.op = '0;
        bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.op = '0;
        test_reset();
        test_add_sub();
        test_reset_mid_mul();
        test_cmp_shift();
        test_mul();
        test_backpressure();
        test_reserved();
        test_random32(300);
        test_random8(2000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
